// File: rtl/instr_sequencer_if.sv
// Switch/button/controller signal bundle for instr_sequencer.
// The sequencer uses the master modport; the controller or a bench uses the slave modport.
interface instr_sequencer_if;
  logic [9:0] SW;
  logic       EXEC_BTN;
  logic       DONE;
  logic [9:0] INSTR;
  logic [1:0] TIME;
  logic       BUSY;
  logic       TIMEOUT;
  logic [7:0] INSTR_CNT;

  modport master (
    input  SW, EXEC_BTN, DONE,
    output INSTR, TIME, BUSY, TIMEOUT, INSTR_CNT
  );

  modport slave (
    output SW, EXEC_BTN, DONE,
    input  INSTR, TIME, BUSY, TIMEOUT, INSTR_CNT
  );
endinterface

// File: rtl/instr_sequencer.sv
// Front end for the 10-bit controller: debounces the execute button, latches SW on
// each accepted press, steps TIME through T0..T3 and ends on DONE or watchdog.
module instr_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  instr_sequencer_if.master   bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e           state_q,       state_d;
  logic             sync1_q,       sync1_d;
  logic             sync2_q,       sync2_d;
  logic [CNT_W-1:0] db_cnt_q,      db_cnt_d;
  logic             db_level_q,    db_level_d;
  logic             db_prev_q,     db_prev_d;
  logic [9:0]       instr_q,       instr_d;
  logic [1:0]       time_q,        time_d;
  logic             busy_q,        busy_d;
  logic             timeout_q,     timeout_d;
  logic [7:0]       instr_cnt_q,   instr_cnt_d;
  logic             grace_q,       grace_d;
  logic             req;

  // Synchronizer and debounce filter.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sync1_d    = bus.EXEC_BTN;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_prev_d  = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      // The counter would reach DEBOUNCE_CYCLES on this edge: commit the new level.
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  assign req = db_level_q & ~db_prev_q;

  // Run-control FSM.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    time_d      = time_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    instr_cnt_d = instr_cnt_q;
    grace_d     = grace_q;

    unique case (state_q)
      IDLE: begin
        time_d = 2'd0;
        busy_d = 1'b0;
        if (req) begin
          instr_d   = bus.SW;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          grace_d   = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        // DONE is checked first so it wins over a watchdog expiring on the same edge.
        if (bus.DONE) begin
          time_d      = 2'd0;
          busy_d      = 1'b0;
          instr_cnt_d = instr_cnt_q + 8'd1;
          state_d     = WAIT_REL;
        end else if (time_q != 2'd3) begin
          time_d = time_q + 2'd1;
        end else if (!grace_q) begin
          // One extra T3 cycle covers the controller's registered DONE.
          grace_d = 1'b1;
        end else begin
          timeout_d = 1'b1;
          time_d    = 2'd0;
          busy_d    = 1'b0;
          state_d   = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (!db_level_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        time_d  = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      instr_q     <= '0;
      time_q      <= 2'd0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      instr_cnt_q <= 8'd0;
      grace_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      instr_q     <= instr_d;
      time_q      <= time_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      instr_cnt_q <= instr_cnt_d;
      grace_q     <= grace_d;
    end
  end

  assign bus.INSTR     = instr_q;
  assign bus.TIME      = time_q;
  assign bus.BUSY      = busy_q;
  assign bus.TIMEOUT   = timeout_q;
  assign bus.INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with DEBOUNCE_CYCLES=4: press timing, bounce,
// watchdog, held button, async reset, counter wrap and DONE-vs-watchdog precedence.
module tb_instr_sequencer;

  localparam int DB = 4;
  localparam int REL_WAIT = DB + 4;

  logic CLK;
  logic RESETn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rises;
  int   acc;

  instr_sequencer_if bus ();

  instr_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input int max_cycles);
    int n = 0;
    while (!bus.BUSY && n < max_cycles) begin
      tick();
      n++;
    end
    check("accept", {31'd0, bus.BUSY}, 32'd1);
  endtask

  // Controller model: raise DONE while T3 is shown, so it is sampled on the next edge.
  task automatic finish_run();
    for (int i = 0; i < 8; i++) begin
      bus.DONE = bus.BUSY && (bus.TIME == 2'd3);
      tick();
      if (!bus.BUSY) break;
    end
    bus.DONE = 1'b0;
    check("complete", {31'd0, bus.BUSY}, 32'd0);
  endtask

  task automatic run_cycles(input int n, output int n_rises);
    logic prev;
    prev    = bus.BUSY;
    n_rises = 0;
    for (int i = 0; i < n; i++) begin
      bus.DONE = bus.BUSY && (bus.TIME == 2'd3);
      tick();
      if (bus.BUSY && !prev) n_rises++;
      prev = bus.BUSY;
    end
    bus.DONE = 1'b0;
  endtask

  task automatic run_one(input logic [9:0] sw);
    bus.SW       = sw;
    bus.EXEC_BTN = 1'b1;
    wait_busy(30);
    finish_run();
    bus.EXEC_BTN = 1'b0;
    repeat (REL_WAIT) tick();
  endtask

  initial begin
    RESETn       = 1'b0;
    bus.SW       = 10'h000;
    bus.EXEC_BTN = 1'b0;
    bus.DONE     = 1'b0;
    #22;
    RESETn = 1'b1;
    tick();

    // Reset state
    check("rst_instr",   {22'd0, bus.INSTR},     32'h0);
    check("rst_time",    {30'd0, bus.TIME},      32'h0);
    check("rst_busy",    {31'd0, bus.BUSY},      32'h0);
    check("rst_timeout", {31'd0, bus.TIMEOUT},   32'h0);
    check("rst_cnt",     {24'd0, bus.INSTR_CNT}, 32'h0);

    // Clean press: accept lands DB+2 edges after the first high sample.
    bus.SW       = 10'h212;
    bus.EXEC_BTN = 1'b1;
    repeat (DB + 2) tick();
    check("t1_busy_early", {31'd0, bus.BUSY}, 32'd0);
    tick();
    check("t1_busy",  {31'd0, bus.BUSY},  32'd1);
    check("t1_instr", {22'd0, bus.INSTR}, 32'h212);
    check("t1_time0", {30'd0, bus.TIME},  32'd0);
    tick(); check("t1_time1", {30'd0, bus.TIME}, 32'd1);
    tick(); check("t1_time2", {30'd0, bus.TIME}, 32'd2);
    tick(); check("t1_time3", {30'd0, bus.TIME}, 32'd3);
    tick(); check("t1_grace", {30'd0, bus.TIME}, 32'd3);
    check("t1_grace_busy", {31'd0, bus.BUSY}, 32'd1);
    // DONE sampled on the watchdog edge: completion must win.
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    check("t1_done_busy",    {31'd0, bus.BUSY},      32'd0);
    check("t1_done_time",    {30'd0, bus.TIME},      32'd0);
    check("t1_done_cnt",     {24'd0, bus.INSTR_CNT}, 32'd1);
    check("t1_done_timeout", {31'd0, bus.TIMEOUT},   32'd0);
    bus.EXEC_BTN = 1'b0;
    repeat (REL_WAIT) tick();
    check("t1_idle", {30'd0, dut.state_q}, 32'd0);

    // Bouncy press: five 2-cycle pulses, then held.
    bus.SW = 10'h155;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.EXEC_BTN = 1'b1;
      run_cycles(2, rises);
      acc += rises;
      bus.EXEC_BTN = 1'b0;
      run_cycles(2, rises);
      acc += rises;
    end
    check("t2_no_bounce_accept", acc, 32'd0);
    bus.EXEC_BTN = 1'b1;
    run_cycles(20, rises);
    check("t2_one_accept", rises, 32'd1);
    check("t2_cnt",   {24'd0, bus.INSTR_CNT}, 32'd2);
    check("t2_instr", {22'd0, bus.INSTR},     32'h155);
    bus.EXEC_BTN = 1'b0;
    repeat (REL_WAIT) tick();

    // Watchdog: DONE never comes.
    bus.SW       = 10'h001;
    bus.EXEC_BTN = 1'b1;
    wait_busy(30);
    check("t3_time0", {30'd0, bus.TIME}, 32'd0);
    tick(); check("t3_time1", {30'd0, bus.TIME}, 32'd1);
    tick(); check("t3_time2", {30'd0, bus.TIME}, 32'd2);
    tick(); check("t3_time3", {30'd0, bus.TIME}, 32'd3);
    tick(); check("t3_grace", {30'd0, bus.TIME}, 32'd3);
    check("t3_grace_timeout", {31'd0, bus.TIMEOUT}, 32'd0);
    tick();
    check("t3_wd_timeout", {31'd0, bus.TIMEOUT},   32'd1);
    check("t3_wd_busy",    {31'd0, bus.BUSY},      32'd0);
    check("t3_wd_time",    {30'd0, bus.TIME},      32'd0);
    check("t3_wd_cnt",     {24'd0, bus.INSTR_CNT}, 32'd2);
    check("t3_wd_state",   {30'd0, dut.state_q},   32'd2);
    bus.EXEC_BTN = 1'b0;
    repeat (REL_WAIT) tick();
    check("t3_sticky", {31'd0, bus.TIMEOUT}, 32'd1);

    // Next accept clears TIMEOUT; SW changes while busy are ignored.
    bus.SW       = 10'h0AB;
    bus.EXEC_BTN = 1'b1;
    wait_busy(30);
    check("t4_timeout_clr", {31'd0, bus.TIMEOUT}, 32'd0);
    check("t4_instr",       {22'd0, bus.INSTR},   32'h0AB);
    bus.SW = 10'h3FF;
    tick();
    check("t4_instr_hold", {22'd0, bus.INSTR}, 32'h0AB);
    finish_run();
    check("t4_cnt", {24'd0, bus.INSTR_CNT}, 32'd3);

    // Button held long after completion: no second run.
    run_cycles(200, rises);
    check("t5_no_rerun", rises, 32'd0);
    check("t5_busy",     {31'd0, bus.BUSY},    32'd0);
    check("t5_state",    {30'd0, dut.state_q}, 32'd2);
    bus.EXEC_BTN = 1'b0;
    repeat (REL_WAIT) tick();
    check("t5_idle", {30'd0, dut.state_q}, 32'd0);
    run_one(10'h2C4);
    check("t5_rerun_cnt", {24'd0, bus.INSTR_CNT}, 32'd4);

    // Asynchronous reset mid-run at TIME=2.
    bus.SW       = 10'h3A5;
    bus.EXEC_BTN = 1'b1;
    wait_busy(30);
    tick();
    tick();
    check("t6_time2", {30'd0, bus.TIME}, 32'd2);
    #2;
    RESETn = 1'b0;
    #1;
    check("t6_time",    {30'd0, bus.TIME},      32'd0);
    check("t6_busy",    {31'd0, bus.BUSY},      32'd0);
    check("t6_instr",   {22'd0, bus.INSTR},     32'd0);
    check("t6_cnt",     {24'd0, bus.INSTR_CNT}, 32'd0);
    check("t6_timeout", {31'd0, bus.TIMEOUT},   32'd0);
    bus.EXEC_BTN = 1'b0;
    #3;
    RESETn = 1'b1;
    tick();
    check("t6_idle", {30'd0, dut.state_q}, 32'd0);
    check("t6_busy_after", {31'd0, bus.BUSY}, 32'd0);

    // Counter wrap after 256 completed instructions.
    for (int i = 0; i < 255; i++) begin
      run_one(10'(i));
    end
    check("t7_cnt_ff", {24'd0, bus.INSTR_CNT}, 32'hFF);
    run_one(10'h3C3);
    check("t7_cnt_wrap", {24'd0, bus.INSTR_CNT}, 32'h00);
    check("t7_instr",    {22'd0, bus.INSTR},     32'h3C3);
    check("t7_timeout",  {31'd0, bus.TIMEOUT},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
